// File: rtl/pdm_mic_emulator.sv
// PDM MEMS microphone emulator: buffers signed PCM samples and emits a
// first-order sigma-delta bit stream in step with a host-supplied M_CLK.
module pdm_mic_emulator #(
  parameter int SAMPLE_WIDTH = 16,
  parameter int OSR          = 64,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enable,
  input  logic [SAMPLE_WIDTH-1:0]       s_data,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic                          M_CLK,
  input  logic                          M_LRSEL,
  output logic                          M_DATA,
  output logic                          M_DATA_OE,
  output logic                          underflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = $clog2(OSR);
  localparam logic [CW-1:0] LAST_BIT   = CW'(OSR - 1);
  localparam logic [LW-1:0] FULL_LEVEL = LW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN
  } state_t;

  // M_CLK synchronizer and edge detect
  logic [1:0] mclk_sync;
  logic       mclk_d;
  logic       rise_p;
  logic       fall_p;

  // Registered edge pulses land 3 clk cycles after the pin toggles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mclk_sync <= '0;
      mclk_d    <= 1'b0;
      rise_p    <= 1'b0;
      fall_p    <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge value of its neighbours, as real hardware does.
      mclk_sync <= {mclk_sync[0], M_CLK};
      mclk_d    <= mclk_sync[1];
      rise_p    <= mclk_sync[1] & ~mclk_d;
      fall_p    <= ~mclk_sync[1] & mclk_d;
    end
  end

  // Sample FIFO
  logic [SAMPLE_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]           wr_ptr;
  logic [AW-1:0]           rd_ptr;
  logic [LW-1:0]           count;
  logic                    full;
  logic                    empty;
  logic                    push;
  logic                    pop;
  logic [SAMPLE_WIDTH-1:0] head;

  // FSM and modulator state
  state_t                  state;
  logic [SAMPLE_WIDTH-1:0] acc;
  logic [SAMPLE_WIDTH-1:0] cur;
  logic [CW-1:0]           bit_cnt;
  logic                    upd_edge;
  logic                    opp_edge;
  logic                    boundary;
  logic [SAMPLE_WIDTH-1:0] u;
  logic [SAMPLE_WIDTH:0]   sum;

  assign full       = (count == FULL_LEVEL);
  assign empty      = (count == '0);
  assign s_ready    = !rst && !full;
  assign push       = s_valid && s_ready;
  assign head       = mem[rd_ptr];
  assign fifo_level = count;

  assign upd_edge = M_LRSEL ? rise_p : fall_p;
  assign opp_edge = M_LRSEL ? fall_p : rise_p;
  assign boundary = (state == RUN) && upd_edge && (bit_cnt == LAST_BIT);

  // A pop only ever happens with the FIFO non-empty; an empty boundary underflows.
  assign pop = (state == LOAD) || (boundary && enable && !empty);

  // Offset-binary view of the sample: -2^(W-1) maps to 0, +2^(W-1)-1 to all ones.
  assign u   = {~cur[SAMPLE_WIDTH-1], cur[SAMPLE_WIDTH-2:0]};
  assign sum = {1'b0, acc} + {1'b0, u};

  // NOTE: the storage array has no reset; emptiness is tracked by the
  // pointers and count alone, which keeps the array a plain RAM.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= s_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + LW'(1);
        2'b01:   count <= count - LW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      acc       <= '0;
      cur       <= '0;
      bit_cnt   <= '0;
      M_DATA    <= 1'b0;
      M_DATA_OE <= 1'b0;
      underflow <= 1'b0;
    end else begin
      underflow <= 1'b0;
      case (state)
        IDLE: begin
          M_DATA_OE <= 1'b0;
          if (enable && !empty) state <= LOAD;
        end
        LOAD: begin
          cur     <= head;
          bit_cnt <= '0;
          state   <= RUN;
        end
        RUN: begin
          if (upd_edge) begin
            acc       <= sum[SAMPLE_WIDTH-1:0];
            M_DATA    <= sum[SAMPLE_WIDTH];
            M_DATA_OE <= 1'b1;
            if (bit_cnt == LAST_BIT) begin
              bit_cnt <= '0;
              if (!enable)     state     <= IDLE;
              else if (!empty) cur       <= head;
              else             underflow <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt + CW'(1);
            end
          end else if (opp_edge) begin
            M_DATA_OE <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pdm_mic_emulator.sv
// Directed bench for pdm_mic_emulator: table of single-sample bit streams
// plus hand-written sequences for FIFO, reset, underflow and LRSEL cases.
module tb_pdm_mic_emulator;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic [15:0] s_data = '0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic        m_clk = 1'b1;
  logic        m_lrsel = 1'b0;
  logic        m_data;
  logic        m_data_oe;
  logic        underflow;
  logic [2:0]  fifo_level;

  pdm_mic_emulator #(.SAMPLE_WIDTH(16), .OSR(64), .FIFO_DEPTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .s_data     (s_data),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .M_CLK      (m_clk),
    .M_LRSEL    (m_lrsel),
    .M_DATA     (m_data),
    .M_DATA_OE  (m_data_oe),
    .underflow  (underflow),
    .fifo_level (fifo_level)
  );

  always #4 clk = ~clk;  // 125 MHz

  int checks = 0;
  int errors = 0;
  int half = 6;          // clk cycles per M_CLK half period
  int uf_seen = 0;
  int oe_bad = 0;
  int lat_bad = 0;

  typedef struct {
    logic        lrsel;
    logic [15:0] sample;
    int          exp_ones;
    logic [7:0]  exp_first8;  // bit i = i-th emitted PDM bit
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    enable = 1'b0;
    s_valid = 1'b0;
    cycles(3);
    rst = 1'b0;
    cycles(8);
  endtask

  task automatic push(input logic [15:0] d, output logic ok);
    s_data = d;
    s_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (s_ready) begin
        cycles(1);
        ok = 1'b1;
        break;
      end
      cycles(1);
    end
    s_valid = 1'b0;
  endtask

  task automatic push_chk(input logic [15:0] d);
    logic ok;
    push(d, ok);
    check("push accepted", {31'd0, ok}, 32'd1);
  endtask

  // Toggle M_CLK and hold it for one half period; lat = clk cycles to first M_DATA change.
  task automatic mclk_toggle(output int lat);
    logic prev;
    prev = m_data;
    m_clk = ~m_clk;
    lat = 0;
    for (int i = 1; i <= half; i++) begin
      cycles(1);
      if (lat == 0 && m_data !== prev) lat = i;
      if (underflow) uf_seen++;
    end
  endtask

  // One emulated bit: optional opposite edge, then the update edge; b is the
  // value the receiver sees at its sampling edge.
  task automatic next_bit(output logic b);
    int   lat;
    logic upd_lvl;
    upd_lvl = m_lrsel;
    if (m_clk === upd_lvl) begin
      mclk_toggle(lat);
      if (m_data_oe !== 1'b0) oe_bad++;
      if (lat != 0) lat_bad++;
    end
    mclk_toggle(lat);
    if (lat != 0 && lat != 4) lat_bad++;
    if (m_data_oe !== 1'b1) oe_bad++;
    b = m_data;
  endtask

  task automatic run_bits(input int n, output int ones, output logic [7:0] first8);
    logic b;
    ones = 0;
    first8 = '0;
    for (int i = 0; i < n; i++) begin
      next_bit(b);
      if (b === 1'b1) ones++;
      if (i < 8) first8[i] = b;
    end
  endtask

  task automatic clear_counters();
    uf_seen = 0;
    oe_bad = 0;
    lat_bad = 0;
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          ones;
    int          ones2;
    logic [7:0]  f8;
    logic        b;
    int          mism;
    int          first_uf;
    int          uf_before;
    int          changes;
    logic        prev;
    logic        ok;
    int          acc_at;

    vecs[0] = '{1'b0, 16'h0000, 32, 8'hAA};
    vecs[1] = '{1'b0, 16'h7FFF, 63, 8'hFE};
    vecs[2] = '{1'b0, 16'h8000,  0, 8'h00};
    vecs[3] = '{1'b0, 16'h4000, 48, 8'hEE};
    vecs[4] = '{1'b0, 16'hC000, 16, 8'h88};
    vecs[5] = '{1'b1, 16'h0000, 32, 8'hAA};
    vecs[6] = '{1'b1, 16'h0001, 32, 8'hAA};
    vecs[7] = '{1'b0, 16'hFFFF, 31, 8'h54};

    // Reset values while rst is held
    cycles(2);
    check("rst s_ready", {31'd0, s_ready}, 32'd0);
    check("rst m_data", {31'd0, m_data}, 32'd0);
    check("rst oe", {31'd0, m_data_oe}, 32'd0);
    check("rst level", {29'd0, fifo_level}, 32'd0);
    rst = 1'b0;
    cycles(1);
    check("ready after rst", {31'd0, s_ready}, 32'd1);

    // 2.4 MHz M_CLK, zero sample: alternating bits, 4-cycle output latency
    do_reset();
    half = 26;
    m_lrsel = 1'b0;
    push_chk(16'h0000);
    enable = 1'b1;
    cycles(4);
    clear_counters();
    mism = 0;
    ones = 0;
    for (int i = 0; i < 64; i++) begin
      next_bit(b);
      if (b !== 1'(i % 2)) mism++;
      if (b === 1'b1) ones++;
    end
    check("zero alt pattern", mism, 0);
    check("zero ones", ones, 32);
    check("zero latency", lat_bad, 0);
    check("zero oe", oe_bad, 0);
    half = 6;

    // Table: one sample per row from a fresh reset, 64 bits each
    for (int r = 0; r < 8; r++) begin
      do_reset();
      m_lrsel = vecs[r].lrsel;
      push_chk(vecs[r].sample);
      enable = 1'b1;
      cycles(4);
      clear_counters();
      run_bits(64, ones, f8);
      check($sformatf("row%0d ones", r), ones, vecs[r].exp_ones);
      check($sformatf("row%0d first8", r), {24'd0, f8}, {24'd0, vecs[r].exp_first8});
      check($sformatf("row%0d underflow", r), uf_seen, 1);
      check($sformatf("row%0d oe", r), oe_bad, 0);
      check($sformatf("row%0d latency", r), lat_bad, 0);
    end

    // Full scale positive then negative
    do_reset();
    m_lrsel = 1'b0;
    push_chk(16'h7FFF);
    push_chk(16'h8000);
    enable = 1'b1;
    cycles(4);
    clear_counters();
    next_bit(b);
    check("7fff first bit", {31'd0, b}, 32'd0);
    run_bits(63, ones, f8);
    check("7fff ones", ones, 63);
    run_bits(64, ones2, f8);
    check("8000 ones", ones2, 0);
    check("7fff/8000 underflow", uf_seen, 1);

    // Single sample repeated: one underflow per 64 edges, stable density
    do_reset();
    push_chk(16'h4000);
    enable = 1'b1;
    cycles(4);
    clear_counters();
    for (int w = 0; w < 3; w++) begin
      uf_before = uf_seen;
      run_bits(64, ones, f8);
      check($sformatf("repeat w%0d ones", w), ones, 48);
      check($sformatf("repeat w%0d underflow", w), uf_seen - uf_before, 1);
    end
    check("repeat level", {29'd0, fifo_level}, 32'd0);

    // FIFO full: 5th push waits for the LOAD pop
    do_reset();
    for (int i = 0; i < 4; i++) push_chk(16'(i * 16'h1111));
    check("full s_ready", {31'd0, s_ready}, 32'd0);
    check("full level", {29'd0, fifo_level}, 32'd4);
    s_data = 16'h1234;
    s_valid = 1'b1;
    cycles(5);
    check("full refused", {29'd0, fifo_level}, 32'd4);
    enable = 1'b1;
    ok = 1'b0;
    acc_at = -1;
    for (int i = 0; i < 10; i++) begin
      if (s_ready) begin
        cycles(1);
        ok = 1'b1;
        acc_at = i;
        break;
      end
      cycles(1);
    end
    s_valid = 1'b0;
    check("5th accepted", {31'd0, ok}, 32'd1);
    check("5th accept cycle", acc_at, 2);
    check("5th level", {29'd0, fifo_level}, 32'd4);

    // LRSEL switched after 4 bits: bit count and pattern continue
    do_reset();
    m_lrsel = 1'b0;
    push_chk(16'h0000);
    enable = 1'b1;
    cycles(4);
    clear_counters();
    mism = 0;
    first_uf = 0;
    for (int i = 0; i < 64; i++) begin
      if (i == 4) m_lrsel = 1'b1;
      uf_before = uf_seen;
      next_bit(b);
      if (b !== 1'(i % 2)) mism++;
      if (uf_seen != uf_before && first_uf == 0) first_uf = i + 1;
    end
    check("lrsel pattern", mism, 0);
    check("lrsel first underflow", first_uf, 64);
    check("lrsel oe", oe_bad, 0);
    check("lrsel latency", lat_bad, 0);

    // No M_CLK edges: outputs hold, no underflow
    prev = m_data;
    changes = 0;
    uf_seen = 0;
    for (int i = 0; i < 200; i++) begin
      cycles(1);
      if (m_data !== prev) changes++;
      if (underflow) uf_seen++;
    end
    check("hold m_data", changes, 0);
    check("hold underflow", uf_seen, 0);

    // Asynchronous reset mid-RUN with 3 samples queued
    do_reset();
    m_lrsel = 1'b0;
    for (int i = 0; i < 4; i++) push_chk(16'h4000);
    enable = 1'b1;
    cycles(4);
    run_bits(6, ones, f8);
    check("pre-rst level", {29'd0, fifo_level}, 32'd3);
    #3;
    rst = 1'b1;
    #1;
    check("mid rst m_data", {31'd0, m_data}, 32'd0);
    check("mid rst oe", {31'd0, m_data_oe}, 32'd0);
    check("mid rst level", {29'd0, fifo_level}, 32'd0);
    check("mid rst acc", {16'd0, dut.acc}, 32'd0);
    check("mid rst s_ready", {31'd0, s_ready}, 32'd0);
    enable = 1'b0;
    cycles(2);
    rst = 1'b0;
    cycles(8);
    push_chk(16'h0000);
    enable = 1'b1;
    cycles(4);
    clear_counters();
    run_bits(8, ones, f8);
    check("post rst first8", {24'd0, f8}, 32'h0000_00AA);
    check("post rst oe", oe_bad, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
